// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one Data_Memory between the CPU load/store path
// (port 0) and the debug/program-loader port (port 1). Fixed priority to
// port 0 with an aging override for port 1; registered read data returned
// with a one-cycle valid pulse to the port that was served.
module data_mem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

    state_t            state, state_nxt;
    logic              sel;          // port on the bus while in ACCESS
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        wait_cnt;

    logic              access;
    logic              misaligned;
    logic              elig0, elig1;
    logic              pick_vld;     // some request selected at this edge
    logic              pick;         // which port wins

    // Saturating increment of the port-1 aging counter.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // Arbitration, next state and bus outputs.
    always_comb begin
        access     = (state == ACCESS);
        misaligned = (addr_q[1:0] != 2'b00);
        // The port being served this cycle still has req high; mask it so it
        // is not served twice before it can drop the request.
        elig0      = req0 && !(access && !sel);
        elig1      = req1 && !(access && sel);
        pick_vld   = elig0 || elig1;
        pick       = elig1 && (!elig0 || (wait_cnt >= MAX_WAIT_C));
        state_nxt  = pick_vld ? ACCESS : IDLE;
        gnt0       = access && !sel;
        gnt1       = access && sel;
        mem_a      = addr_q;
        mem_wd     = wdata_q;
        // Reset gates the write enable directly so a store in flight is killed.
        mem_we     = access && we_q && !misaligned && !reset;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Request latch, aging counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= 3'd0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            rvalid0 <= access && !sel;
            rvalid1 <= access && sel;
            if (access) begin
                rdata <= mem_rd;
                err   <= misaligned;
            end
            if (pick_vld) begin
                sel     <= pick;
                we_q    <= pick ? we1    : we0;
                addr_q  <= pick ? addr1  : addr0;
                wdata_q <= pick ? wdata1 : wdata0;
            end
            if (req1 && !(pick_vld && pick)) wait_cnt <= sat_inc(wait_cnt);
            else                             wait_cnt <= 3'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic on both
// ports, checked against a transaction-level reference model and scoreboard.
module tb_data_mem_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
    logic [DATA_W-1:0] rdata, mem_wd, mem_rd;
    logic [ADDR_W-1:0] mem_a;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Data_Memory stand-in: 256 words, combinational read, write at edge.
    logic [DATA_W-1:0] mem [0:255];
    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_a[9:2]] <= mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: which port owns the bus each cycle, the memory image
    // after each completed access, and the result each port should receive.
    typedef struct packed { logic [31:0] rdata; logic err; } res_t;
    res_t              q0[$], q1[$];
    logic [DATA_W-1:0] ref_mem [0:255];
    int                m_busy = -1;   // port on the bus this cycle, -1 none
    int                m_rv   = -1;   // port whose result is due this cycle
    int                m_wait = 0;    // edges port 1 has been passed over
    logic              m_we;
    logic [31:0]       m_addr, m_wd;

    always @(posedge clk) begin
        res_t r;
        int   nb;
        logic e0, e1;
        if (cyc == 0) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        m_rv = -1;
        if (!reset && m_busy != -1) begin
            r.rdata = ref_mem[m_addr[9:2]];
            r.err   = (m_addr[1:0] != 2'b00);
            if (m_busy == 0) q0.push_back(r); else q1.push_back(r);
            if (m_we && !r.err) ref_mem[m_addr[9:2]] = m_wd;
            m_rv = m_busy;
        end
        if (reset) begin
            m_busy = -1;
            m_wait = 0;
        end else begin
            e0 = req0 && (m_busy != 0);
            e1 = req1 && (m_busy != 1);
            if (e0 && e1)  nb = (m_wait >= MAX_WAIT) ? 1 : 0;
            else if (e0)   nb = 0;
            else if (e1)   nb = 1;
            else           nb = -1;
            m_wait = (req1 && nb != 1) ? ((m_wait < 7) ? m_wait + 1 : 7) : 0;
            if (nb == 0) begin m_we = we0; m_addr = addr0; m_wd = wdata0; end
            if (nb == 1) begin m_we = we1; m_addr = addr1; m_wd = wdata1; end
            m_busy = nb;
        end
    end

    // Monitor: compare bus activity and returned results against the model.
    always @(negedge clk) begin
        res_t r;
        if (cyc >= 1) begin
            check("gnt0", 32'(gnt0), 32'(m_busy == 0));
            check("gnt1", 32'(gnt1), 32'(m_busy == 1));
            check("mem_we", 32'(mem_we),
                  32'(m_busy != -1 && m_we && m_addr[1:0] == 2'b00 && !reset));
            if (m_busy != -1) begin
                check("mem_a", mem_a, m_addr);
                check("mem_wd", mem_wd, m_wd);
            end
            check("rvalid0", 32'(rvalid0), 32'(m_rv == 0));
            check("rvalid1", 32'(rvalid1), 32'(m_rv == 1));
            if (m_rv == 0 && q0.size() > 0) begin
                r = q0.pop_front();
                check("rdata0", rdata, r.rdata);
                check("err0", 32'(err), 32'(r.err));
            end
            if (m_rv == 1 && q1.size() > 0) begin
                r = q1.pop_front();
                check("rdata1", rdata, r.rdata);
                check("err1", 32'(err), 32'(r.err));
            end
        end
    end

    // Requester: present a held request, wait for its grant, then drop it.
    // Entered and left at #1 after a rising edge.
    task automatic port_op(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        forever begin
            @(negedge clk);
            if ((p == 0 && gnt0) || (p == 1 && gnt1)) break;
            n++;
            if (n > 100) begin
                n_tests++; n_fail++;
                $display("FAIL grant_timeout port%0d: got no gnt, expected gnt within 100 cycles", p);
                break;
            end
        end
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic rand_traffic(input int p, input int count);
        logic [31:0] a;
        for (int k = 0; k < count; k++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            port_op(p, 1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Store then load on port 0.
        port_op(0, 1'b1, 32'h10, 32'hDEADBEEF);
        port_op(0, 1'b0, 32'h10, 32'h0);
        check("store_word_0x10", mem[4], 32'hDEADBEEF);
        repeat (2) begin @(posedge clk); #1; end

        // Simultaneous first requests from IDLE.
        fork
            port_op(0, 1'b0, 32'h20, 32'h0);
            port_op(1, 1'b0, 32'h24, 32'h0);
        join
        repeat (2) begin @(posedge clk); #1; end

        // Port 1 store while port 0 streams loads.
        fork
            begin
                for (int k = 0; k < 6; k++) port_op(0, 1'b0, 32'(k) << 2, 32'h0);
            end
            port_op(1, 1'b1, 32'h40, 32'h55);
        join
        repeat (2) begin @(posedge clk); #1; end
        check("store_word_0x40", mem[16], 32'h55);

        // Misaligned store must not write.
        port_op(1, 1'b1, 32'h13, 32'h1);
        repeat (2) begin @(posedge clk); #1; end
        check("misaligned_word_0x10", mem[4], 32'hDEADBEEF);

        // Reset during the ACCESS cycle of a store.
        port_op(0, 1'b1, 32'h08, 32'h12345678);
        repeat (2) begin @(posedge clk); #1; end
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h08; wdata0 = 32'hFFFFFFFF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_access_gnt0", 32'(gnt0), 32'h1);
        check("rst_access_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; req0 = 1'b0;
        @(negedge clk);
        check("post_rst_gnt0", 32'(gnt0), 32'h0);
        check("post_rst_rvalid0", 32'(rvalid0), 32'h0);
        check("post_rst_rdata", rdata, 32'h0);
        check("post_rst_err", 32'(err), 32'h0);
        check("post_rst_mem_a", mem_a, 32'h0);
        check("rst_word_0x08", mem[2], 32'h12345678);
        @(posedge clk); #1;

        // Randomized concurrent traffic on both ports.
        fork
            rand_traffic(0, 60);
            rand_traffic(1, 60);
        join
        repeat (4) begin @(posedge clk); #1; end
        check("scoreboard_q0_empty", 32'(q0.size()), 32'h0);
        check("scoreboard_q1_empty", 32'(q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
